// File: rtl/ser_pkg.sv
// Shared types and defaults for the ser_word_rx serial receiver slice.
package ser_pkg;

    typedef enum logic [0:0] {IDLE, SHIFT} ser_state_t;

    localparam int unsigned SER_WIDTH_DEF = 8;

endpackage

// File: rtl/ser_word_rx_if.sv
// Serial-input and word-output signal bundle for ser_word_rx.
interface ser_word_rx_if
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH_DEF
) ();

    logic             Start;
    logic             Bit_Valid;
    logic             Serial_In;
    logic             Out_Ready;
    logic             Clr_Err;
    logic [WIDTH-1:0] Data_Out;
    logic             Out_Valid;
    logic             Busy;
    logic             Abort;
    logic             Overrun;
    logic             Parity_Err;

    modport master (
        output Start, Bit_Valid, Serial_In, Out_Ready, Clr_Err,
        input  Data_Out, Out_Valid, Busy, Abort, Overrun, Parity_Err
    );

    modport slave (
        input  Start, Bit_Valid, Serial_In, Out_Ready, Clr_Err,
        output Data_Out, Out_Valid, Busy, Abort, Overrun, Parity_Err
    );

endinterface

// File: rtl/ser_out_buf.sv
// One-word output holding register with valid/ready handshake and sticky Overrun.
module ser_out_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             perr,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             overrun,
    output logic             parity_err
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             perr_q, perr_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovr_d   = clr_err ? 1'b0 : ovr_q;
        if (load && (!valid_q || out_ready)) begin
            // Load while the old word is being taken keeps valid high with no bubble.
            data_d  = word;
            perr_d  = perr;
            valid_d = 1'b1;
        end else if (load) begin
            ovr_d   = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    assign data_out   = data_q;
    assign out_valid  = valid_q;
    assign overrun    = ovr_q;
    assign parity_err = perr_q;

endmodule

// File: rtl/ser_word_rx.sv
// LSB-first serial-to-parallel receiver with valid/ready word output.
// Define SER_WORD_RX_PARITY_EN to append a trailing even-parity bit to each frame.
module ser_word_rx
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    ser_word_rx_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 2);
`ifdef SER_WORD_RX_PARITY_EN
    localparam int unsigned FRAME_N = WIDTH + 1;
`else
    localparam int unsigned FRAME_N = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_N - 1);
    localparam logic [CNT_W-1:0] DATA_N   = CNT_W'(WIDTH);

    ser_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             par_q, par_d;
    logic             abort_q, abort_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             load;
    logic             perr;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            par_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            par_q   <= par_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        par_d   = par_q;
        load    = 1'b0;
        word    = sreg_q;
        perr    = 1'b0;
        shifted = sreg_q;
        // Start (re)arms from a clean slate first, so a same-cycle bit lands as bit 0.
        if (bus.Start) begin
            state_d = SHIFT;
            cnt_d   = '0;
            sreg_d  = '0;
            par_d   = 1'b0;
        end
        if ((bus.Start || state_q == SHIFT) && bus.Bit_Valid) begin
            shifted = {bus.Serial_In, sreg_d[WIDTH-1:1]};
            if (cnt_d == LAST_IDX) begin
                state_d = IDLE;
                cnt_d   = '0;
                load    = 1'b1;
`ifdef SER_WORD_RX_PARITY_EN
                word    = sreg_d;
                perr    = par_d ^ bus.Serial_In;
`else
                word    = shifted;
`endif
            end else begin
                if (cnt_d < DATA_N) begin
                    sreg_d = shifted;
                    par_d  = par_d ^ bus.Serial_In;
                end
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    always_comb begin
        bus.Busy = (state_q == SHIFT);
        abort_d  = bus.Start && (state_q == SHIFT);
    end

    assign bus.Abort = abort_q;

    ser_out_buf #(.WIDTH(WIDTH)) u_out_buf (
        .Clk        (Clk),
        .Reset      (Reset),
        .load       (load),
        .word       (word),
        .perr       (perr),
        .out_ready  (bus.Out_Ready),
        .clr_err    (bus.Clr_Err),
        .data_out   (bus.Data_Out),
        .out_valid  (bus.Out_Valid),
        .overrun    (bus.Overrun),
        .parity_err (bus.Parity_Err)
    );

endmodule

// File: tb/tb_ser_word_rx.sv
// Directed self-checking bench for ser_word_rx (default build and SER_WORD_RX_PARITY_EN).
module tb_ser_word_rx;
    import ser_pkg::*;

    localparam int unsigned W = SER_WIDTH_DEF;
`ifdef SER_WORD_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   failures = 0;

    ser_word_rx_if #(.WIDTH(W)) bus ();

    ser_word_rx #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.Bit_Valid = 1'b1;
        bus.Serial_In = b;
        tick();
        bus.Bit_Valid = 1'b0;
        bus.Serial_In = 1'b0;
    endtask

    task automatic start_pulse();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    // gap>0 inserts (k mod (gap+1)) idle cycles before data bit k; rdy/clr_last raise
    // Out_Ready / Clr_Err for the final bit of the frame.
    task automatic send_frame(input logic [W-1:0] w, input int gap, input logic bad_par,
                              input logic rdy_last, input logic clr_last);
        start_pulse();
        for (int k = 0; k < W; k++) begin
            for (int g = 0; g < (k % (gap + 1)); g++) tick();
            if (!PAR && k == W - 1) begin
                if (rdy_last) bus.Out_Ready = 1'b1;
                if (clr_last) bus.Clr_Err = 1'b1;
            end
            send_bit(w[k]);
        end
        if (PAR) begin
            if (rdy_last) bus.Out_Ready = 1'b1;
            if (clr_last) bus.Clr_Err = 1'b1;
            send_bit((^w) ^ bad_par);
        end
        bus.Clr_Err = 1'b0;
    endtask

    task automatic drain();
        bus.Out_Ready = 1'b1;
        tick();
        bus.Out_Ready = 1'b0;
    endtask

    initial begin
        Reset         = 1'b1;
        bus.Start     = 1'b0;
        bus.Bit_Valid = 1'b0;
        bus.Serial_In = 1'b0;
        bus.Out_Ready = 1'b0;
        bus.Clr_Err   = 1'b0;
        bus.Start     = 1'b1;
        bus.Bit_Valid = 1'b1;
        tick();
        tick();
        Reset         = 1'b0;
        bus.Start     = 1'b0;
        bus.Bit_Valid = 1'b0;

        chk("rst_data",  32'(bus.Data_Out), 32'h0);
        chk("rst_valid", 32'(bus.Out_Valid), 32'h0);
        chk("rst_busy",  32'(bus.Busy), 32'h0);
        chk("rst_abort", 32'(bus.Abort), 32'h0);
        chk("rst_ovr",   32'(bus.Overrun), 32'h0);
        chk("rst_perr",  32'(bus.Parity_Err), 32'h0);

        // Bits without Start are ignored in IDLE.
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        chk("idle_busy",  32'(bus.Busy), 32'h0);
        chk("idle_valid", 32'(bus.Out_Valid), 32'h0);

        // 1: back-to-back 0xA5, Out_Ready high.
        bus.Out_Ready = 1'b1;
        start_pulse();
        chk("t1_busy_start", 32'(bus.Busy), 32'h1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        chk("t1_mid_valid", 32'(bus.Out_Valid), 32'h0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        if (PAR) begin
            send_bit(1'b1);
            chk("t1_pre_par_valid", 32'(bus.Out_Valid), 32'h0);
            send_bit(1'b0);
        end else begin
            send_bit(1'b1);
        end
        chk("t1_data",  32'(bus.Data_Out), 32'hA5);
        chk("t1_valid", 32'(bus.Out_Valid), 32'h1);
        chk("t1_busy",  32'(bus.Busy), 32'h0);
        tick();
        chk("t1_valid_clr", 32'(bus.Out_Valid), 32'h0);
        chk("t1_data_hold", 32'(bus.Data_Out), 32'hA5);
        bus.Out_Ready = 1'b0;

        // 2: gapped 0xA5, held until Out_Ready.
        send_frame(8'hA5, 3, 1'b0, 1'b0, 1'b0);
        chk("t2_valid", 32'(bus.Out_Valid), 32'h1);
        tick(); tick(); tick();
        chk("t2_hold_valid", 32'(bus.Out_Valid), 32'h1);
        chk("t2_hold_data",  32'(bus.Data_Out), 32'hA5);
        drain();
        chk("t2_taken", 32'(bus.Out_Valid), 32'h0);

        // 3: overrun and Clr_Err.
        send_frame(8'h3C, 0, 1'b0, 1'b0, 1'b0);
        chk("t3_first_ovr", 32'(bus.Overrun), 32'h0);
        send_frame(8'hC3, 0, 1'b0, 1'b0, 1'b0);
        chk("t3_data",  32'(bus.Data_Out), 32'h3C);
        chk("t3_ovr",   32'(bus.Overrun), 32'h1);
        chk("t3_valid", 32'(bus.Out_Valid), 32'h1);
        bus.Clr_Err = 1'b1;
        tick();
        bus.Clr_Err = 1'b0;
        chk("t3_clr", 32'(bus.Overrun), 32'h0);
        send_frame(8'h77, 0, 1'b0, 1'b0, 1'b1);
        chk("t3_clr_vs_set", 32'(bus.Overrun), 32'h1);
        chk("t3_data2", 32'(bus.Data_Out), 32'h3C);
        drain();
        chk("t3_drained", 32'(bus.Out_Valid), 32'h0);
        bus.Clr_Err = 1'b1;
        tick();
        bus.Clr_Err = 1'b0;

        // 4: 0x01 then 0x80, second completing as the first is accepted.
        send_frame(8'h01, 0, 1'b0, 1'b0, 1'b0);
        chk("t4_first", 32'(bus.Data_Out), 32'h01);
        send_frame(8'h80, 0, 1'b0, 1'b1, 1'b0);
        chk("t4_second", 32'(bus.Data_Out), 32'h80);
        chk("t4_no_bubble", 32'(bus.Out_Valid), 32'h1);
        chk("t4_no_ovr", 32'(bus.Overrun), 32'h0);
        tick();
        chk("t4_taken", 32'(bus.Out_Valid), 32'h0);
        bus.Out_Ready = 1'b0;

        // 5a: restart after 4 bits, then 0x5A.
        start_pulse();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("t5_abort_pre", 32'(bus.Abort), 32'h0);
        bus.Start     = 1'b1;
        bus.Bit_Valid = 1'b1;
        bus.Serial_In = 1'b0;
        tick();
        bus.Start     = 1'b0;
        bus.Bit_Valid = 1'b0;
        chk("t5_abort", 32'(bus.Abort), 32'h1);
        chk("t5_busy",  32'(bus.Busy), 32'h1);
        tick();
        chk("t5_abort_end", 32'(bus.Abort), 32'h0);
        begin
            logic [7:0] v5 = 8'h5A;
            for (int k = 1; k < 8; k++) send_bit(v5[k]);
            if (PAR) send_bit(^v5);
        end
        chk("t5_data",  32'(bus.Data_Out), 32'h5A);
        chk("t5_valid", 32'(bus.Out_Valid), 32'h1);
        chk("t5_perr",  32'(bus.Parity_Err), 32'h0);

        // 5b: Reset mid-frame with a word still buffered.
        start_pulse();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("t5r_data",  32'(bus.Data_Out), 32'h0);
        chk("t5r_valid", 32'(bus.Out_Valid), 32'h0);
        chk("t5r_busy",  32'(bus.Busy), 32'h0);
        chk("t5r_ovr",   32'(bus.Overrun), 32'h0);
        send_frame(8'h96, 0, 1'b0, 1'b0, 1'b0);
        chk("t5r_next",  32'(bus.Data_Out), 32'h96);
        chk("t5r_abort", 32'(bus.Abort), 32'h0);
        drain();

`ifdef SER_WORD_RX_PARITY_EN
        // 6: parity good then bad.
        send_frame(8'hA5, 0, 1'b0, 1'b0, 1'b0);
        chk("t6_good_perr", 32'(bus.Parity_Err), 32'h0);
        drain();
        send_frame(8'hA5, 0, 1'b1, 1'b0, 1'b0);
        chk("t6_bad_perr", 32'(bus.Parity_Err), 32'h1);
        chk("t6_bad_data", 32'(bus.Data_Out), 32'hA5);
        drain();
`else
        send_frame(8'hFE, 0, 1'b0, 1'b0, 1'b0);
        chk("t6_perr_tied", 32'(bus.Parity_Err), 32'h0);
        chk("t6_data", 32'(bus.Data_Out), 32'hFE);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
